hazard_scheduler: RTL and testbench
===================================

# hazard_scheduler

Pipeline hazard scheduler for the five-stage ARM core (IF, ID, EXE, MEM, WB). It keeps its own scoreboard of the instructions in EXE, MEM and WB, and from it drives:
- the stall request into the ID stage;
- the freeze and flush controls for the pipeline registers;
- the operand forwarding selects for EXE.

It sits beside the ID stage and consumes that stage's source, destination and control outputs.

## Interface
- FORWARD, 1: 1 = forwarding enabled, so only load-use stalls; 0 = stall on any RAW dependence in EXE or MEM.
- CNT_W, 16: width of the stall-cycle performance counter.

- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- id_src1  in  4  Rn index of the instruction in ID.
- id_src2  in  4  second source index (Rm, or Rd for stores) of the instruction in ID.
- id_two_src  in  1  id_src2 is a real operand.
- id_dest  in  4  destination register of the instruction in ID.
- id_wb_en  in  1  ID instruction writes the register file (already gated by its condition).
- id_mem_r_en  in  1  ID instruction is a load.
- branch_taken  in  1  EXE resolves a taken branch this cycle.
- mem_busy  in  1  data memory not ready; the whole pipeline must hold.
- hazard  out  1  stall ID/IF; ID must inject a bubble.
- freeze  out  1  hold all pipeline registers.
- flush  out  1  clear the IF/ID register.
- fwd_sel1  out  2  EXE operand-1 source: 0 = register file, 1 = MEM-stage ALU result, 2 = WB value.
- fwd_sel2  out  2  EXE operand-2 source; same encoding as fwd_sel1.
- stall_count  out  CNT_W  saturating count of stall cycles.

## Operation
- **Scoreboard slots.** There are three slots: EXE, MEM, WB.
  - Each slot holds: valid, dest[3:0], wb_en, mem_r_en, src1[3:0], src2[3:0], two_src.
  - Only EXE uses its src fields.
- **Slot advance (when freeze = 0).**
  - WB takes MEM; MEM takes EXE.
  - EXE takes the ID fields with valid = 1.
  - Exception: if hazard = 1 or flush = 1 that cycle, EXE takes a bubble (valid = 0, wb_en = 0, mem_r_en = 0).
- **Freeze.** freeze = mem_busy. While freeze = 1, every slot holds.
- **Dependency match.** A slot S "matches" source r when S.valid & S.wb_en & (S.dest == r).
  - For src2, the match also requires id_two_src = 1.
- **Hazard, FORWARD = 0.**
  - hazard = (EXE or MEM matches id_src1) | (EXE or MEM matches id_src2).
- **Hazard, FORWARD = 1.**
  - hazard = EXE.mem_r_en & (EXE matches id_src1 | EXE matches id_src2).
  - This is load-use only.
- **Hazard gating.** hazard is forced to 0 while freeze = 1 or flush = 1.
- **Forwarding selects (FORWARD = 1, EXE.valid = 1).**
  - fwd_sel1 = 1 if MEM matches EXE.src1 and MEM.mem_r_en = 0.
  - Otherwise fwd_sel1 = 2 if WB matches EXE.src1.
  - Otherwise fwd_sel1 = 0.
  - fwd_sel2 follows the same rules using EXE.src2, gated by EXE.two_src.
  - MEM has priority over WB.
  - When FORWARD = 0 or EXE.valid = 0, both selects are 0.
- **Flush.** flush = branch_taken & ~freeze. A taken branch during freeze is deferred until freeze drops; EXE holds the branch.
- **Stall counter.** stall_count increments when (hazard | freeze) is 1 on a rising edge. It saturates at 2^CNT_W − 1.
- **Reset (reset = 0).** All slots invalid with zero fields; stall_count = 0.
  - Outputs: hazard = 0, flush = 0, fwd_sel1 = fwd_sel2 = 0, stall_count = 0.
  - freeze follows mem_busy.
  - Reset asserted mid-operation discards all in-flight scoreboard state.
- **R15 dependences.** These are treated like any other register; the block has no special case.

## Timing
- hazard, freeze, flush and fwd_sel* are combinational from the current ID inputs, the slot registers and mem_busy. They are valid in the same cycle.
- Slots and stall_count update on the rising edge after the cycle in which their inputs were sampled.
- FORWARD = 1 load-use stall:
  - lasts exactly 1 cycle;
  - the next cycle uses fwd_sel = 2 from WB.
- FORWARD = 0 stall lengths:
  - 2 cycles for a dependence on EXE;
  - 1 cycle for a dependence on MEM.
- Simultaneous branch_taken and hazard (not frozen): flush wins, hazard = 0, and EXE gets a bubble.
- Simultaneous mem_busy and branch_taken: only freeze = 1; flush follows on the first cycle with mem_busy = 0.

## Test plan
- **Reset:** reset = 0 mid-stream with slots loaded, release, ID presents src1 = 3 with no writer in flight -> all slots invalid, hazard = 0, fwd_sel1 = fwd_sel2 = 0, stall_count = 0.
- **ALU dependence, FORWARD = 1:** ADD R1 then SUB R2,R1,R4 -> hazard stays 0; in the SUB's EXE cycle fwd_sel1 = 1; a third instruction reading R1 two behind gets fwd_sel1 = 2.
- **Load-use, FORWARD = 1:** LDR R5 then ADD R6,R5,R7 -> hazard = 1 for exactly 1 cycle, EXE bubble inserted, then fwd_sel1 = 2; stall_count = 1.
- **FORWARD = 0:** ADD R1 then ORR R2,R1,#4 -> hazard = 1 for 2 cycles. With an immediate operand (id_two_src = 0), an EXE dest equal to id_src2 must not stall.
- **Branch vs. hazard:** branch_taken = 1 while ID has a load-use dependence -> flush = 1, hazard = 0, EXE slot becomes a bubble next cycle.
- **Freeze:** mem_busy = 1 for 3 cycles together with branch_taken = 1 -> freeze = 1, slots unchanged, flush = 0 for 3 cycles; then flush = 1 in the fourth cycle; stall_count increases by 3.

Source files
------------

// File: rtl/hazard_scheduler.sv
// rtl/hazard_scheduler.sv - pipeline hazard scheduler: stall, freeze, flush and forwarding control
//
// Keeps a private scoreboard of the instructions in EXE, MEM and WB. From it, and
// from the ID stage's operand/control outputs, it derives:
//   hazard       : stall IF/ID and inject a bubble into EXE
//   freeze       : hold every pipeline register (data memory busy)
//   flush        : clear IF/ID after a taken branch
//   fwd_sel1/2   : EXE operand source (0 = regfile, 1 = MEM ALU result, 2 = WB value)
//   stall_count  : saturating count of cycles spent in hazard or freeze
// Inputs: clk, reset (async, active-low), id_src1, id_src2, id_two_src, id_dest,
//         id_wb_en, id_mem_r_en, branch_taken, mem_busy.
// FORWARD = 1 stalls only on load-use; FORWARD = 0 stalls on any RAW in EXE or MEM.

module hazard_scheduler #(
    parameter bit FORWARD = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic [3:0]       id_dest,
    input  logic             id_wb_en,
    input  logic             id_mem_r_en,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             hazard,
    output logic             freeze,
    output logic             flush,
    output logic [1:0]       fwd_sel1,
    output logic [1:0]       fwd_sel2,
    output logic [CNT_W-1:0] stall_count
);

    // Only the EXE slot needs source operands (forwarding looks at them).
    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
        logic [3:0] src1;
        logic [3:0] src2;
        logic       two_src;
    } exe_slot_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       wb_en;
        logic       mem_r_en;
    } mem_slot_t;

    exe_slot_t  exe_q;
    exe_slot_t  id_slot;
    mem_slot_t  mem_q;
    logic       wb_valid;
    logic       wb_wb_en;
    logic [3:0] wb_dest;

    logic exe_m1, exe_m2, mem_m1, mem_m2;
    logic raw_hazard;
    logic mem_f1, mem_f2, wb_f1, wb_f2;

    always_comb begin
        id_slot = '{valid:    1'b1,
                    dest:     id_dest,
                    wb_en:    id_wb_en,
                    mem_r_en: id_mem_r_en,
                    src1:     id_src1,
                    src2:     id_src2,
                    two_src:  id_two_src};
    end

    // Hazard detection against the instruction waiting in ID.
    always_comb begin
        exe_m1 = exe_q.valid & exe_q.wb_en & (exe_q.dest == id_src1);
        exe_m2 = id_two_src & exe_q.valid & exe_q.wb_en & (exe_q.dest == id_src2);
        mem_m1 = mem_q.valid & mem_q.wb_en & (mem_q.dest == id_src1);
        mem_m2 = id_two_src & mem_q.valid & mem_q.wb_en & (mem_q.dest == id_src2);

        if (FORWARD) begin
            // Only a load in EXE cannot be bypassed in time.
            raw_hazard = exe_q.mem_r_en & (exe_m1 | exe_m2);
        end else begin
            raw_hazard = exe_m1 | exe_m2 | mem_m1 | mem_m2;
        end

        freeze = mem_busy;
        // A branch seen during freeze is retried once memory is ready: EXE still holds it.
        flush  = branch_taken & ~mem_busy;
        // Flush squashes the dependent instruction anyway, so it never also stalls.
        hazard = raw_hazard & ~mem_busy & ~flush;
    end

    // Forwarding for the instruction currently in EXE; MEM is younger so it wins.
    // A load in MEM has no data yet and is never a forwarding source.
    always_comb begin
        mem_f1 = mem_q.valid & mem_q.wb_en & ~mem_q.mem_r_en & (mem_q.dest == exe_q.src1);
        mem_f2 = mem_q.valid & mem_q.wb_en & ~mem_q.mem_r_en & (mem_q.dest == exe_q.src2);
        wb_f1  = wb_valid & wb_wb_en & (wb_dest == exe_q.src1);
        wb_f2  = wb_valid & wb_wb_en & (wb_dest == exe_q.src2);

        fwd_sel1 = 2'd0;
        fwd_sel2 = 2'd0;
        if (FORWARD && exe_q.valid) begin
            if (mem_f1)     fwd_sel1 = 2'd1;
            else if (wb_f1) fwd_sel1 = 2'd2;

            if (exe_q.two_src) begin
                if (mem_f2)     fwd_sel2 = 2'd1;
                else if (wb_f2) fwd_sel2 = 2'd2;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exe_q       <= '0;
            mem_q       <= '0;
            wb_valid    <= 1'b0;
            wb_wb_en    <= 1'b0;
            wb_dest     <= 4'd0;
            stall_count <= '0;
        end else begin
            if (!freeze) begin
                wb_valid <= mem_q.valid;
                wb_wb_en <= mem_q.wb_en;
                wb_dest  <= mem_q.dest;
                mem_q    <= '{valid:    exe_q.valid,
                              dest:     exe_q.dest,
                              wb_en:    exe_q.wb_en,
                              mem_r_en: exe_q.mem_r_en};
                if (hazard || flush) begin
                    exe_q <= '0;
                end else begin
                    exe_q <= id_slot;
                end
            end

            if ((hazard || freeze) && (stall_count != {CNT_W{1'b1}})) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scheduler.sv
// tb/tb_hazard_scheduler.sv - directed self-checking bench for hazard_scheduler

module tb_hazard_scheduler;

    logic       clk;
    logic       reset;
    logic [3:0] id_src1, id_src2, id_dest;
    logic       id_two_src, id_wb_en, id_mem_r_en;
    logic       branch_taken, mem_busy;

    // FORWARD = 1 instance
    logic        hz_f, fz_f, fl_f;
    logic [1:0]  s1_f, s2_f;
    logic [15:0] sc_f;
    // FORWARD = 0 instance
    logic        hz_n, fz_n, fl_n;
    logic [1:0]  s1_n, s2_n;
    logic [15:0] sc_n;
    // narrow counter instance
    logic        hz_s, fz_s, fl_s;
    logic [1:0]  s1_s, s2_s;
    logic [1:0]  sc_s;

    int checks = 0;
    int errors = 0;

    hazard_scheduler #(.FORWARD(1'b1), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .hazard(hz_f), .freeze(fz_f), .flush(fl_f), .fwd_sel1(s1_f), .fwd_sel2(s2_f),
        .stall_count(sc_f));

    hazard_scheduler #(.FORWARD(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .hazard(hz_n), .freeze(fz_n), .flush(fl_n), .fwd_sel1(s1_n), .fwd_sel2(s2_n),
        .stall_count(sc_n));

    hazard_scheduler #(.FORWARD(1'b1), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_dest(id_dest), .id_wb_en(id_wb_en),
        .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken), .mem_busy(mem_busy),
        .hazard(hz_s), .freeze(fz_s), .flush(fl_s), .fwd_sel1(s1_s), .fwd_sel2(s2_s),
        .stall_count(sc_s));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_id(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                          input logic [3:0] d, input logic wb, input logic mr);
        id_src1 = s1; id_src2 = s2; id_two_src = two;
        id_dest = d;  id_wb_en = wb; id_mem_r_en = mr;
    endtask

    // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        branch_taken = 1'b0;
        mem_busy = 1'b0;
        set_id(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
    endtask

    initial begin
        // ---------------- reset state ----------------
        reset = 1'b0;
        branch_taken = 1'b0;
        mem_busy = 1'b1;
        set_id(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #3;
        chk("rst_freeze_follows_busy", fz_f, 1);
        chk("rst_hazard", hz_f, 0);
        chk("rst_flush", fl_f, 0);
        chk("rst_fwd1", s1_f, 0);
        chk("rst_fwd2", s2_f, 0);
        tick();
        chk("rst_count_held", sc_f, 0);
        mem_busy = 1'b0;
        tick();
        reset = 1'b1;
        set_id(4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1;
        chk("rst_rel_hazard_nofwd", hz_n, 0);
        chk("rst_rel_fwd1", s1_f, 0);

        // ---------------- ALU dependence, FORWARD = 1 ----------------
        do_reset();
        set_id(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);          // ADD R1,R2,R3
        #1; chk("alu_a_hazard", hz_f, 0);
        tick();
        set_id(4'd1, 4'd4, 1'b1, 4'd2, 1'b1, 1'b0);          // SUB R2,R1,R4
        #1; chk("alu_b_hazard", hz_f, 0);
        chk("alu_b_fwd1", s1_f, 0);
        tick();
        set_id(4'd1, 4'd2, 1'b1, 4'd3, 1'b1, 1'b0);          // EOR R3,R1,R2
        #1; chk("alu_c_hazard", hz_f, 0);
        chk("alu_c_fwd1_mem", s1_f, 1);
        chk("alu_c_fwd2", s2_f, 0);
        tick();
        set_id(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1; chk("alu_d_fwd1_wb", s1_f, 2);
        chk("alu_d_fwd2_mem", s2_f, 1);
        chk("alu_d_count", sc_f, 0);

        // ---------------- load-use, FORWARD = 1 ----------------
        do_reset();
        set_id(4'd6, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);          // LDR R5,[R6]
        #1; chk("lu_1_hazard", hz_f, 0);
        tick();
        set_id(4'd5, 4'd7, 1'b1, 4'd6, 1'b1, 1'b0);          // ADD R6,R5,R7
        #1; chk("lu_2_hazard", hz_f, 1);
        tick();
        #1; chk("lu_3_hazard", hz_f, 0);
        chk("lu_3_fwd1_bubble", s1_f, 0);
        chk("lu_3_count", sc_f, 1);
        tick();
        set_id(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        #1; chk("lu_4_fwd1_wb", s1_f, 2);
        chk("lu_4_count", sc_f, 1);

        // ---------------- FORWARD = 0 ----------------
        do_reset();
        set_id(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);          // ADD R1,R2,R3
        tick();
        set_id(4'd1, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0);          // ORR R2,R1,#4
        #1; chk("nf_1_hazard_exe", hz_n, 1);
        tick();
        #1; chk("nf_2_hazard_mem", hz_n, 1);
        tick();
        set_id(4'd0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0);          // MOV R9,#imm
        #1; chk("nf_3_hazard", hz_n, 0);
        chk("nf_3_count", sc_n, 2);
        chk("nf_3_fwd1_off", s1_n, 0);
        tick();
        set_id(4'd10, 4'd9, 1'b0, 4'd11, 1'b1, 1'b0);        // src2 = R9 but immediate
        #1; chk("nf_imm_no_stall", hz_n, 0);
        id_two_src = 1'b1;
        #1; chk("nf_reg_src2_stall", hz_n, 1);
        id_two_src = 1'b0;

        // ---------------- branch vs. hazard ----------------
        do_reset();
        set_id(4'd6, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);          // LDR R5,[R6]
        tick();
        set_id(4'd5, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1);          // LDR R5,[R5]
        branch_taken = 1'b1;
        #1; chk("br_flush", fl_f, 1);
        chk("br_hazard_masked", hz_f, 0);
        tick();
        branch_taken = 1'b0;
        set_id(4'd5, 4'd0, 1'b0, 4'd7, 1'b1, 1'b0);
        #1; chk("br_exe_bubble", hz_f, 0);
        chk("br_flush_gone", fl_f, 0);
        chk("br_count", sc_f, 0);

        // ---------------- freeze with pending branch ----------------
        do_reset();
        set_id(4'd2, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0);          // ADD R1
        tick();
        set_id(4'd1, 4'd4, 1'b1, 4'd2, 1'b1, 1'b0);          // SUB R2,R1,R4
        tick();
        set_id(4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        mem_busy = 1'b1;
        branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("frz_freeze", fz_f, 1);
            chk("frz_flush", fl_f, 0);
            chk("frz_slots_held", s1_f, 1);
            tick();
        end
        mem_busy = 1'b0;
        #1; chk("frz_flush_after", fl_f, 1);
        chk("frz_freeze_off", fz_f, 0);
        chk("frz_count", sc_f, 3);
        tick();
        branch_taken = 1'b0;
        #1; chk("frz_exe_bubble", s1_f, 0);
        chk("frz_count_hold", sc_f, 3);

        // ---------------- counter saturation ----------------
        do_reset();
        mem_busy = 1'b1;
        repeat (5) tick();
        mem_busy = 1'b0;
        #1; chk("sat_narrow", sc_s, 3);
        chk("sat_wide", sc_f, 5);

        // ---------------- reset mid-stream ----------------
        set_id(4'd1, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0);          // writers of R3
        tick();
        tick();
        set_id(4'd3, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0);
        #1; chk("mid_pre_hazard", hz_n, 1);
        reset = 1'b0;
        #1; chk("mid_async_count", sc_f, 0);
        chk("mid_async_hazard", hz_n, 0);
        tick();
        reset = 1'b1;
        #1; chk("mid_rel_hazard", hz_n, 0);
        chk("mid_rel_fwd1", s1_f, 0);
        chk("mid_rel_fwd2", s2_f, 0);
        chk("mid_rel_count", sc_n, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
